// File: rtl/hazard_scoreboard_if.sv
// rtl/hazard_scoreboard_if.sv - decode-side bundle between the ID stage and the hazard scoreboard
interface hazard_scoreboard_if #(
   parameter int REG_AW = 3,
   parameter int STAGES = 3,
   parameter int CNT_W  = 16
);
   localparam int SEL_W = $clog2(STAGES + 1);

   logic              id_valid;
   logic [REG_AW-1:0] id_src1;
   logic              id_src1_en;
   logic [REG_AW-1:0] id_src2;
   logic              id_src2_en;
   logic [REG_AW-1:0] id_dst;
   logic              id_wr;
   logic              id_load;
   logic              flush;
   logic              stall;
   logic [SEL_W-1:0]  fwd1_sel;
   logic [SEL_W-1:0]  fwd2_sel;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output id_valid, id_src1, id_src1_en, id_src2, id_src2_en,
             id_dst, id_wr, id_load, flush,
      input  stall, fwd1_sel, fwd2_sel, stall_cnt
   );

   modport slave (
      input  id_valid, id_src1, id_src1_en, id_src2, id_src2_en,
             id_dst, id_wr, id_load, flush,
      output stall, fwd1_sel, fwd2_sel, stall_cnt
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - decode hazard detection, forwarding selects and stall counting
module hazard_scoreboard #(
   parameter int REG_AW   = 3,
   parameter int STAGES   = 3,
   parameter int LOAD_LAT = 1,
   parameter int FWD_EN   = 1,
   parameter int FLUSH_N  = 1,
   parameter int CNT_W    = 16
) (
   input  logic               clk,
   input  logic               rst,
   hazard_scoreboard_if.slave bus
);
   localparam int SEL_W = $clog2(STAGES + 1);

   logic [STAGES-1:0] v_q, v_d;
   logic [STAGES-1:0] ld_q, ld_d;
   logic [REG_AW-1:0] dst_q [STAGES];
   logic [REG_AW-1:0] dst_d [STAGES];
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic              hit1, hit2;
   logic              haz1, haz2;
   logic              stall;
   logic [SEL_W-1:0]  sel1, sel2;

   // Scan oldest to youngest so the youngest matching entry is the one left standing.
   always_comb begin
      hit1 = 1'b0;
      haz1 = 1'b0;
      sel1 = '0;
      hit2 = 1'b0;
      haz2 = 1'b0;
      sel2 = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
         if (bus.id_valid && bus.id_src1_en && v_q[k] && (dst_q[k] == bus.id_src1)) begin
            hit1 = 1'b1;
            haz1 = (FWD_EN == 0) || (ld_q[k] && (k < LOAD_LAT));
            sel1 = SEL_W'(k + 1);
         end
         if (bus.id_valid && bus.id_src2_en && v_q[k] && (dst_q[k] == bus.id_src2)) begin
            hit2 = 1'b1;
            haz2 = (FWD_EN == 0) || (ld_q[k] && (k < LOAD_LAT));
            sel2 = SEL_W'(k + 1);
         end
      end
   end

   assign stall         = haz1 | haz2;
   assign bus.stall     = stall;
   assign bus.fwd1_sel  = (hit1 && !stall) ? sel1 : '0;
   assign bus.fwd2_sel  = (hit2 && !stall) ? sel2 : '0;
   assign bus.stall_cnt = cnt_q;

   // Flush squashes the youngest FLUSH_N entries before the shift; older ones advance intact.
   always_comb begin
      v_d  = '0;
      ld_d = '0;
      for (int k = 0; k < STAGES; k++) begin
         dst_d[k] = '0;
      end
      v_d[0]   = bus.id_valid & bus.id_wr & ~stall & ~bus.flush;
      dst_d[0] = bus.id_dst;
      ld_d[0]  = bus.id_load;
      for (int k = 0; k < STAGES - 1; k++) begin
         v_d[k+1]   = v_q[k] & ~(bus.flush && (k < FLUSH_N));
         dst_d[k+1] = dst_q[k];
         ld_d[k+1]  = ld_q[k];
      end
      cnt_d = cnt_q;
      if (stall && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         v_q   <= '0;
         ld_q  <= '0;
         cnt_q <= '0;
         for (int k = 0; k < STAGES; k++) begin
            dst_q[k] <= '0;
         end
      end else begin
         v_q   <= v_d;
         ld_q  <= ld_d;
         cnt_q <= cnt_d;
         for (int k = 0; k < STAGES; k++) begin
            dst_q[k] <= dst_d[k];
         end
      end
   end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed vector bench for hazard_scoreboard
module tb_hazard_scoreboard;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   hazard_scoreboard_if #(.REG_AW(3), .STAGES(3), .CNT_W(16)) ifa ();
   hazard_scoreboard_if #(.REG_AW(3), .STAGES(3), .CNT_W(16)) ifn ();
   hazard_scoreboard_if #(.REG_AW(3), .STAGES(3), .CNT_W(4))  ifc ();

   hazard_scoreboard #(.REG_AW(3), .STAGES(3), .LOAD_LAT(1), .FWD_EN(1), .FLUSH_N(1), .CNT_W(16))
      u_a (.clk(clk), .rst(rst), .bus(ifa.slave));
   hazard_scoreboard #(.REG_AW(3), .STAGES(3), .LOAD_LAT(1), .FWD_EN(0), .FLUSH_N(1), .CNT_W(16))
      u_n (.clk(clk), .rst(rst), .bus(ifn.slave));
   hazard_scoreboard #(.REG_AW(3), .STAGES(3), .LOAD_LAT(1), .FWD_EN(1), .FLUSH_N(1), .CNT_W(4))
      u_c (.clk(clk), .rst(rst), .bus(ifc.slave));

   typedef struct {
      logic       v;
      logic [2:0] s1;
      logic       s1e;
      logic [2:0] s2;
      logic       s2e;
      logic [2:0] d;
      logic       wr;
      logic       ld;
      logic       fl;
      int         st;
      int         f1;
      int         f2;
      int         cnt;
   } vec_t;

   vec_t tbl [29];

   function automatic vec_t mk(input logic v, input int s1, input logic s1e, input int s2,
                               input logic s2e, input int d, input logic wr, input logic ld,
                               input logic fl, input int st, input int f1, input int f2,
                               input int cnt);
      vec_t r;
      r.v = v;   r.s1 = 3'(s1); r.s1e = s1e; r.s2 = 3'(s2); r.s2e = s2e;
      r.d = 3'(d); r.wr = wr; r.ld = ld; r.fl = fl;
      r.st = st; r.f1 = f1; r.f2 = f2; r.cnt = cnt;
      return r;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic apply_a(input vec_t r);
      ifa.id_valid = r.v;   ifa.id_src1 = r.s1; ifa.id_src1_en = r.s1e;
      ifa.id_src2 = r.s2;   ifa.id_src2_en = r.s2e;
      ifa.id_dst = r.d;     ifa.id_wr = r.wr;   ifa.id_load = r.ld; ifa.flush = r.fl;
   endtask

   task automatic idle_all();
      apply_a(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      ifn.id_valid = 0; ifn.id_src1 = 0; ifn.id_src1_en = 0; ifn.id_src2 = 0;
      ifn.id_src2_en = 0; ifn.id_dst = 0; ifn.id_wr = 0; ifn.id_load = 0; ifn.flush = 0;
      ifc.id_valid = 0; ifc.id_src1 = 0; ifc.id_src1_en = 0; ifc.id_src2 = 0;
      ifc.id_src2_en = 0; ifc.id_dst = 0; ifc.id_wr = 0; ifc.id_load = 0; ifc.flush = 0;
   endtask

   initial begin
      //            v s1 e s2 e d wr ld fl  st f1 f2 cnt
      tbl[0]  = mk(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0);
      tbl[1]  = mk(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
      tbl[2]  = mk(1, 2, 1, 2, 1, 0, 0, 0, 0, 0, 2, 2, 0);
      tbl[3]  = mk(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0);
      tbl[4]  = mk(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[5]  = mk(1, 0, 0, 0, 0, 4, 1, 1, 0, 0, 0, 0, 0);
      tbl[6]  = mk(1, 4, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      tbl[7]  = mk(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 1);
      tbl[8]  = mk(0, 4, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      tbl[9]  = mk(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0, 0, 1);
      tbl[10] = mk(1, 5, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1);
      tbl[11] = mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      tbl[12] = mk(1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0, 0, 1);
      tbl[13] = mk(1, 6, 1, 0, 0, 6, 1, 0, 1, 1, 0, 0, 1);
      tbl[14] = mk(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
      tbl[15] = mk(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 2);
      tbl[16] = mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2);
      tbl[17] = mk(1, 3, 1, 1, 1, 0, 0, 0, 1, 0, 2, 1, 2);
      tbl[18] = mk(1, 3, 1, 1, 1, 0, 0, 0, 0, 0, 3, 0, 2);
      tbl[19] = mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 2);
      tbl[20] = mk(1, 7, 1, 0, 0, 7, 1, 0, 0, 0, 1, 0, 2);
      tbl[21] = mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2);
      tbl[22] = mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 2);
      tbl[23] = mk(1, 7, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0, 2);
      tbl[24] = mk(1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 2);
      tbl[25] = mk(1, 2, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 2);
      tbl[26] = mk(1, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 2);
      tbl[27] = mk(1, 2, 1, 1, 1, 0, 0, 0, 0, 1, 0, 0, 2);
      tbl[28] = mk(1, 2, 1, 1, 1, 0, 0, 0, 0, 0, 0, 2, 3);

      idle_all();
      // Reset held two cycles with a self-dependent load sitting in decode
      rst = 1'b0;
      apply_a(mk(1, 3, 1, 3, 1, 3, 1, 1, 0, 0, 0, 0, 0));
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("reset stall", int'(ifa.stall), 0);
      chk("reset fwd1", int'(ifa.fwd1_sel), 0);
      chk("reset fwd2", int'(ifa.fwd2_sel), 0);
      chk("reset cnt", int'(ifa.stall_cnt), 0);
      chk("reset cnt nofwd", int'(ifn.stall_cnt), 0);

      for (int i = 0; i < 29; i++) begin
         @(negedge clk);
         apply_a(tbl[i]);
         #1;
         chk($sformatf("row%0d stall", i), int'(ifa.stall), tbl[i].st);
         chk($sformatf("row%0d fwd1", i), int'(ifa.fwd1_sel), tbl[i].f1);
         chk($sformatf("row%0d fwd2", i), int'(ifa.fwd2_sel), tbl[i].f2);
         chk($sformatf("row%0d cnt", i), int'(ifa.stall_cnt), tbl[i].cnt);
      end
      @(negedge clk);
      apply_a(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

      // No forwarding: ALU RAW stalls until the producer retires
      for (int c = 0; c < 5; c++) begin
         if (c == 0) begin
            ifn.id_valid = 1; ifn.id_dst = 3'd1; ifn.id_wr = 1; ifn.id_src1_en = 0;
         end else begin
            ifn.id_valid = 1; ifn.id_wr = 0; ifn.id_src1 = 3'd1; ifn.id_src1_en = 1;
         end
         #1;
         chk($sformatf("nofwd c%0d stall", c), int'(ifn.stall), (c >= 1 && c <= 3) ? 1 : 0);
         chk($sformatf("nofwd c%0d fwd1", c), int'(ifn.fwd1_sel), 0);
         if (c == 4) chk("nofwd cnt", int'(ifn.stall_cnt), 3);
         @(negedge clk);
      end
      ifn.id_valid = 0; ifn.id_src1_en = 0;

      // Saturation: a self-dependent load in decode stalls every other cycle
      ifc.id_valid = 1; ifc.id_dst = 3'd4; ifc.id_wr = 1; ifc.id_load = 1;
      ifc.id_src1 = 3'd4; ifc.id_src1_en = 1;
      for (int c = 0; c < 41; c++) begin
         #1;
         chk($sformatf("sat c%0d stall", c), int'(ifc.stall), c % 2);
         chk($sformatf("sat c%0d cnt", c), int'(ifc.stall_cnt), (c / 2 > 15) ? 15 : c / 2);
         @(negedge clk);
      end
      ifc.id_valid = 0; ifc.id_src1_en = 0;
      #1;
      chk("sat final cnt", int'(ifc.stall_cnt), 15);

      // Reset mid-flight drops tracked writes and clears the counter
      @(negedge clk);
      apply_a(mk(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0, 0, 0));
      @(negedge clk);
      rst = 1'b0;
      apply_a(mk(1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midrst stall", int'(ifa.stall), 0);
      chk("midrst fwd1", int'(ifa.fwd1_sel), 0);
      chk("midrst cnt", int'(ifa.stall_cnt), 0);
      chk("midrst cnt sat", int'(ifc.stall_cnt), 0);
      @(negedge clk);
      #1;
      chk("midrst next fwd1", int'(ifa.fwd1_sel), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
